// File: rtl/keypad_debounce_encoder.sv
// Debounced one-hot keypad encoder: rejects multi-key presses, emits one
// active-low load strobe per debounced press and waits for a debounced release.
module keypad_debounce_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enablen,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [CODE_W-1:0]   BCD_OUT,
    output logic                loadn,
    output logic                key_held,
    output logic                multi_err
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_KEYS-1:0] KEY_ONE  = NUM_KEYS'(1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        HOLD,
        RELEASE
    } state_t;

    state_t              r_state;
    logic [NUM_KEYS-1:0] r_snapshot;
    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_bcd;
    logic                r_loadn;
    logic                r_key_held;
    logic                r_multi_err;

    logic w_any;
    logic w_onehot;
    logic w_match;
    logic w_cnt_done;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign w_any      = (keypad != '0);
    assign w_onehot   = w_any && ((keypad & (keypad - KEY_ONE)) == '0);
    assign w_match    = (keypad == r_snapshot);
    assign w_cnt_done = (r_cnt == CNT_LAST);

    function automatic logic [CODE_W-1:0] f_encode(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) c = CODE_W'(i);
        end
        return c;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_snapshot  <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_loadn     <= 1'b1;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
        end else if (enablen) begin
            r_state     <= IDLE;
            r_loadn     <= 1'b1;
            r_key_held  <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_loadn     <= 1'b1;
            r_multi_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_snapshot <= keypad;
                        r_cnt      <= '0;
                        r_state    <= DEBOUNCE;
                    end else if (w_any) begin
                        r_multi_err <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!w_match) begin
                        r_state <= IDLE;
                    end else if (w_cnt_done) begin
                        r_bcd   <= f_encode(r_snapshot);
                        r_loadn <= 1'b0;
                        r_state <= EMIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                EMIT: begin
                    r_key_held <= 1'b1;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (!w_any) begin
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_any) begin
                        r_state <= HOLD;
                    end else if (w_cnt_done) begin
                        r_key_held <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BCD_OUT   = r_bcd;
    assign loadn     = r_loadn;
    assign key_held  = r_key_held;
    assign multi_err = r_multi_err;
endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder (NUM_KEYS=10, DEBOUNCE_CYCLES=4).
module tb_keypad_debounce_encoder;
    logic       clock = 1'b0;
    logic       reset;
    logic       enablen;
    logic [9:0] keypad;
    logic [3:0] BCD_OUT;
    logic       loadn;
    logic       key_held;
    logic       multi_err;

    int n_asserts = 0;
    int n_fails   = 0;

    keypad_debounce_encoder #(
        .NUM_KEYS       (10),
        .CODE_W         (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enablen  (enablen),
        .keypad   (keypad),
        .BCD_OUT  (BCD_OUT),
        .loadn    (loadn),
        .key_held (key_held),
        .multi_err(multi_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Key already driven; first IDLE sample is the next edge, strobe after the 5th.
    task automatic press_expect(input logic [3:0] code);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("press_wait_loadn", loadn, 1);
        end
        tick();
        chk("press_strobe_loadn", loadn, 0);
        chk("press_strobe_bcd", BCD_OUT, code);
        tick();
        chk("press_hold_loadn", loadn, 1);
        chk("press_hold_key_held", key_held, 1);
    endtask

    // First zero moves HOLD->RELEASE, then four counted zeros reach IDLE.
    task automatic release_expect();
        keypad = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("release_wait_key_held", key_held, 1);
        end
        tick();
        chk("release_done_key_held", key_held, 0);
        chk("release_done_loadn", loadn, 1);
    endtask

    initial begin
        reset   = 1'b1;
        enablen = 1'b0;
        keypad  = '0;
        #1;
        chk("reset_bcd", BCD_OUT, 0);
        chk("reset_loadn", loadn, 1);
        chk("reset_key_held", key_held, 0);
        chk("reset_multi_err", multi_err, 0);
        tick();
        tick();
        reset = 1'b0;

        // Clean press of key 5, no auto-repeat while held, debounced release.
        keypad = 10'b0000100000;
        press_expect(4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_repeat_loadn", loadn, 1);
        end
        release_expect();

        // Key 9 bounces off after two cycles, then is held stable.
        keypad = 10'b1000000000;
        tick();
        tick();
        keypad = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_bounce_loadn", loadn, 1);
            chk("t3_bounce_bcd", BCD_OUT, 5);
        end
        keypad = 10'b1000000000;
        press_expect(4'd9);
        keypad = 10'b1000000010;
        tick();
        chk("t3_hold_extra_multi_err", multi_err, 0);
        chk("t3_hold_extra_loadn", loadn, 1);
        chk("t3_hold_extra_bcd", BCD_OUT, 9);
        release_expect();

        // Two keys in IDLE: multi_err every cycle, no strobe.
        keypad = 10'b0000000011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_multi_err", multi_err, 1);
            chk("t4_loadn", loadn, 1);
            chk("t4_bcd", BCD_OUT, 9);
        end
        keypad = '0;
        tick();
        chk("t4_multi_err_clear", multi_err, 0);

        // Key 3 with a bouncing release.
        keypad = 10'b0000001000;
        press_expect(4'd3);
        begin
            logic [6:0] seq;
            seq = 7'b0010000;
            for (int i = 6; i >= 0; i--) begin
                keypad = seq[i] ? 10'b0000001000 : 10'b0000000000;
                tick();
                chk("t5_bounce_key_held", key_held, 1);
                chk("t5_bounce_loadn", loadn, 1);
            end
        end
        keypad = '0;
        tick();
        chk("t5_idle_key_held", key_held, 0);
        chk("t5_bcd", BCD_OUT, 3);

        // Key 7 held while disabled, then enabled.
        enablen = 1'b1;
        keypad  = 10'b0010000000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_disabled_loadn", loadn, 1);
            chk("t6_disabled_key_held", key_held, 0);
        end
        enablen = 1'b0;
        press_expect(4'd7);
        release_expect();

        // Disable during EMIT cancels the strobe after one cycle.
        keypad = 10'b0000000100;
        for (int i = 0; i < 4; i++) tick();
        tick();
        chk("emit_cancel_strobe", loadn, 0);
        chk("emit_cancel_bcd", BCD_OUT, 2);
        enablen = 1'b1;
        tick();
        chk("emit_cancel_loadn", loadn, 1);
        chk("emit_cancel_key_held", key_held, 0);
        chk("emit_cancel_bcd_kept", BCD_OUT, 2);
        keypad = '0;
        tick();
        enablen = 1'b0;
        tick();
        chk("emit_cancel_idle_loadn", loadn, 1);

        // Reset in the middle of debouncing key 5.
        keypad = 10'b0000100000;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t1_reset_bcd", BCD_OUT, 0);
        chk("t1_reset_loadn", loadn, 1);
        chk("t1_reset_key_held", key_held, 0);
        tick();
        chk("t1_reset_hold_loadn", loadn, 1);
        reset = 1'b0;
        press_expect(4'd5);
        release_expect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
